// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are
// resolved from the CDBs, then issues the lowest-index ready entry to the ALU.
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int ROB_ID_W = 5,
    parameter int OPENUM_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_dsp,
    input  logic [OPENUM_W-1:0] openum_from_dsp,
    input  logic [31:0]         V1_from_dsp,
    input  logic [31:0]         V2_from_dsp,
    input  logic [ROB_ID_W-1:0] Q1_from_dsp,
    input  logic [ROB_ID_W-1:0] Q2_from_dsp,
    input  logic [31:0]         pc_from_dsp,
    input  logic [31:0]         imm_from_dsp,
    input  logic [ROB_ID_W-1:0] rob_id_from_dsp,
    input  logic                valid_from_rs_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_rs_cdb,
    input  logic [31:0]         result_from_rs_cdb,
    input  logic                valid_from_ls_cdb,
    input  logic [ROB_ID_W-1:0] rob_id_from_ls_cdb,
    input  logic [31:0]         result_from_ls_cdb,
    input  logic                rollback_from_rob,
    output logic                full_to_if,
    output logic                ena_to_alu,
    output logic [OPENUM_W-1:0] openum_to_alu,
    output logic [31:0]         V1_to_alu,
    output logic [31:0]         V2_to_alu,
    output logic [31:0]         pc_to_alu,
    output logic [31:0]         imm_to_alu,
    output logic [ROB_ID_W-1:0] rob_id_to_alu
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0]  r_busy;
    logic [OPENUM_W-1:0] r_openum [RS_SIZE];
    logic [31:0]         r_v1     [RS_SIZE];
    logic [31:0]         r_v2     [RS_SIZE];
    logic [ROB_ID_W-1:0] r_q1     [RS_SIZE];
    logic [ROB_ID_W-1:0] r_q2     [RS_SIZE];
    logic [31:0]         r_pc     [RS_SIZE];
    logic [31:0]         r_imm    [RS_SIZE];
    logic [ROB_ID_W-1:0] r_rob    [RS_SIZE];

    logic [CNT_W-1:0]    w_free_cnt;
    logic                w_wr_hit;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_is_hit;
    logic [IDX_W-1:0]    w_is_idx;
    logic [31:0]         w_in_v1;
    logic [31:0]         w_in_v2;
    logic [ROB_ID_W-1:0] w_in_q1;
    logic [ROB_ID_W-1:0] w_in_q2;

    // Descending scan so the last hit is the lowest index; write uses the pre-issue free set.
    always_comb begin
        w_free_cnt = '0;
        w_wr_hit   = 1'b0;
        w_wr_idx   = '0;
        w_is_hit   = 1'b0;
        w_is_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            w_free_cnt = w_free_cnt + CNT_W'(!r_busy[i]);
            if (!r_busy[i]) begin
                w_wr_hit = 1'b1;
                w_wr_idx = IDX_W'(i);
            end
            if (r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0)) begin
                w_is_hit = 1'b1;
                w_is_idx = IDX_W'(i);
            end
        end
    end

    assign full_to_if = (w_free_cnt < CNT_W'(2));

    always_comb begin
        w_in_v1 = V1_from_dsp;
        w_in_q1 = Q1_from_dsp;
        if (Q1_from_dsp != '0 && valid_from_rs_cdb && rob_id_from_rs_cdb == Q1_from_dsp) begin
            w_in_v1 = result_from_rs_cdb;
            w_in_q1 = '0;
        end else if (Q1_from_dsp != '0 && valid_from_ls_cdb && rob_id_from_ls_cdb == Q1_from_dsp) begin
            w_in_v1 = result_from_ls_cdb;
            w_in_q1 = '0;
        end
        w_in_v2 = V2_from_dsp;
        w_in_q2 = Q2_from_dsp;
        if (Q2_from_dsp != '0 && valid_from_rs_cdb && rob_id_from_rs_cdb == Q2_from_dsp) begin
            w_in_v2 = result_from_rs_cdb;
            w_in_q2 = '0;
        end else if (Q2_from_dsp != '0 && valid_from_ls_cdb && rob_id_from_ls_cdb == Q2_from_dsp) begin
            w_in_v2 = result_from_ls_cdb;
            w_in_q2 = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            ena_to_alu    <= 1'b0;
            openum_to_alu <= '0;
            V1_to_alu     <= '0;
            V2_to_alu     <= '0;
            pc_to_alu     <= '0;
            imm_to_alu    <= '0;
            rob_id_to_alu <= '0;
        end else if (rdy) begin
            if (rollback_from_rob) begin
                r_busy     <= '0;
                ena_to_alu <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i]) begin
                        if (r_q1[i] != '0 && valid_from_rs_cdb && rob_id_from_rs_cdb == r_q1[i]) begin
                            r_v1[i] <= result_from_rs_cdb;
                            r_q1[i] <= '0;
                        end else if (r_q1[i] != '0 && valid_from_ls_cdb && rob_id_from_ls_cdb == r_q1[i]) begin
                            r_v1[i] <= result_from_ls_cdb;
                            r_q1[i] <= '0;
                        end
                        if (r_q2[i] != '0 && valid_from_rs_cdb && rob_id_from_rs_cdb == r_q2[i]) begin
                            r_v2[i] <= result_from_rs_cdb;
                            r_q2[i] <= '0;
                        end else if (r_q2[i] != '0 && valid_from_ls_cdb && rob_id_from_ls_cdb == r_q2[i]) begin
                            r_v2[i] <= result_from_ls_cdb;
                            r_q2[i] <= '0;
                        end
                    end
                end

                ena_to_alu <= w_is_hit;
                if (w_is_hit) begin
                    openum_to_alu    <= r_openum[w_is_idx];
                    V1_to_alu        <= r_v1[w_is_idx];
                    V2_to_alu        <= r_v2[w_is_idx];
                    pc_to_alu        <= r_pc[w_is_idx];
                    imm_to_alu       <= r_imm[w_is_idx];
                    rob_id_to_alu    <= r_rob[w_is_idx];
                    r_busy[w_is_idx] <= 1'b0;
                end

                // A write with no free entry is dropped rather than clobbering a busy one.
                if (ena_from_dsp && w_wr_hit) begin
                    r_busy[w_wr_idx]   <= 1'b1;
                    r_openum[w_wr_idx] <= openum_from_dsp;
                    r_v1[w_wr_idx]     <= w_in_v1;
                    r_v2[w_wr_idx]     <= w_in_v2;
                    r_q1[w_wr_idx]     <= w_in_q1;
                    r_q2[w_wr_idx]     <= w_in_q2;
                    r_pc[w_wr_idx]     <= pc_from_dsp;
                    r_imm[w_wr_idx]    <= imm_from_dsp;
                    r_rob[w_wr_idx]    <= rob_id_from_dsp;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues are queued when
// instructions are dispatched and popped when ena_to_alu is observed.
module tb_reservation_station;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ena_from_dsp;
    logic [5:0]  openum_from_dsp;
    logic [31:0] V1_from_dsp, V2_from_dsp;
    logic [4:0]  Q1_from_dsp, Q2_from_dsp;
    logic [31:0] pc_from_dsp, imm_from_dsp;
    logic [4:0]  rob_id_from_dsp;
    logic        valid_from_rs_cdb;
    logic [4:0]  rob_id_from_rs_cdb;
    logic [31:0] result_from_rs_cdb;
    logic        valid_from_ls_cdb;
    logic [4:0]  rob_id_from_ls_cdb;
    logic [31:0] result_from_ls_cdb;
    logic        rollback_from_rob;
    logic        full_to_if;
    logic        ena_to_alu;
    logic [5:0]  openum_to_alu;
    logic [31:0] V1_to_alu, V2_to_alu, pc_to_alu, imm_to_alu;
    logic [4:0]  rob_id_to_alu;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rob;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    reservation_station #(.RS_SIZE(16), .ROB_ID_W(5), .OPENUM_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ena_from_dsp(ena_from_dsp), .openum_from_dsp(openum_from_dsp),
        .V1_from_dsp(V1_from_dsp), .V2_from_dsp(V2_from_dsp),
        .Q1_from_dsp(Q1_from_dsp), .Q2_from_dsp(Q2_from_dsp),
        .pc_from_dsp(pc_from_dsp), .imm_from_dsp(imm_from_dsp),
        .rob_id_from_dsp(rob_id_from_dsp),
        .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb),
        .result_from_rs_cdb(result_from_rs_cdb),
        .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb),
        .result_from_ls_cdb(result_from_ls_cdb),
        .rollback_from_rob(rollback_from_rob),
        .full_to_if(full_to_if), .ena_to_alu(ena_to_alu),
        .openum_to_alu(openum_to_alu), .V1_to_alu(V1_to_alu), .V2_to_alu(V2_to_alu),
        .pc_to_alu(pc_to_alu), .imm_to_alu(imm_to_alu), .rob_id_to_alu(rob_id_to_alu)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        ena_from_dsp       = 1'b0;
        valid_from_rs_cdb  = 1'b0;
        valid_from_ls_cdb  = 1'b0;
        rollback_from_rob  = 1'b0;
        rob_id_from_rs_cdb = '0;
        rob_id_from_ls_cdb = '0;
        result_from_rs_cdb = '0;
        result_from_ls_cdb = '0;
    endtask

    function automatic logic [31:0] pc_of(input logic [4:0] rob);
        return 32'h1000 + 32'(rob) * 4;
    endfunction

    function automatic logic [31:0] imm_of(input logic [4:0] rob);
        return 32'(rob) * 16 + 32'd3;
    endfunction

    task automatic drive_write(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] q1,
                               input logic [31:0] v2, input logic [4:0] q2, input logic [4:0] rob);
        ena_from_dsp    = 1'b1;
        openum_from_dsp = op;
        V1_from_dsp     = v1;
        Q1_from_dsp     = q1;
        V2_from_dsp     = v2;
        Q2_from_dsp     = q2;
        rob_id_from_dsp = rob;
        pc_from_dsp     = pc_of(rob);
        imm_from_dsp    = imm_of(rob);
    endtask

    task automatic push_exp(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [4:0] rob);
        exp_t e;
        e.op  = op;
        e.v1  = v1;
        e.v2  = v2;
        e.pc  = pc_of(rob);
        e.imm = imm_of(rob);
        e.rob = rob;
        exp_q.push_back(e);
    endtask

    task automatic cdb_rs(input logic [4:0] tag, input logic [31:0] res);
        valid_from_rs_cdb  = 1'b1;
        rob_id_from_rs_cdb = tag;
        result_from_rs_cdb = res;
    endtask

    task automatic cdb_ls(input logic [4:0] tag, input logic [31:0] res);
        valid_from_ls_cdb  = 1'b1;
        rob_id_from_ls_cdb = tag;
        result_from_ls_cdb = res;
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".ena"}, 32'(ena_to_alu), 32'd0);
    endtask

    task automatic expect_issue(input string tag);
        exp_t e;
        chk({tag, ".ena"}, 32'(ena_to_alu), 32'd1);
        chk({tag, ".sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rob"}, 32'(rob_id_to_alu), 32'(e.rob));
            chk({tag, ".op"},  32'(openum_to_alu), 32'(e.op));
            chk({tag, ".v1"},  V1_to_alu, e.v1);
            chk({tag, ".v2"},  V2_to_alu, e.v2);
            chk({tag, ".pc"},  pc_to_alu, e.pc);
            chk({tag, ".imm"}, imm_to_alu, e.imm);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        openum_from_dsp = '0;
        V1_from_dsp = '0; V2_from_dsp = '0; Q1_from_dsp = '0; Q2_from_dsp = '0;
        pc_from_dsp = '0; imm_from_dsp = '0; rob_id_from_dsp = '0;
        clr_inputs();
        tick();
        tick();
        chk("rst.ena", 32'(ena_to_alu), 32'd0);
        chk("rst.v1", V1_to_alu, 32'd0);
        chk("rst.rob", 32'(rob_id_to_alu), 32'd0);
        chk("rst.full", 32'(full_to_if), 32'd0);
        rst = 1'b0;

        // basic ready instruction
        drive_write(6'd1, 32'd5, 5'd0, 32'd7, 5'd0, 5'd3);
        push_exp(6'd1, 32'd5, 32'd7, 5'd3);
        tick(); clr_inputs();
        expect_idle("basic.lat");
        tick();
        expect_issue("basic");
        tick();
        expect_idle("basic.freed");
        chk("basic.full", 32'(full_to_if), 32'd0);

        // wake-up of Q1 via rs_cdb; non-matching ls tag must not wake
        drive_write(6'd2, 32'hDEAD, 5'd4, 32'd2, 5'd0, 5'd5);
        push_exp(6'd2, 32'h10, 32'd2, 5'd5);
        tick(); clr_inputs();
        cdb_ls(5'd7, 32'h77);
        tick(); clr_inputs();
        expect_idle("wake.wait");
        cdb_rs(5'd4, 32'h10);
        tick(); clr_inputs();
        expect_idle("wake.lat");
        tick();
        expect_issue("wake");

        // write-time forwarding from ls_cdb on Q2
        drive_write(6'd3, 32'd3, 5'd0, 32'hBEEF, 5'd6, 5'd7);
        cdb_ls(5'd6, 32'hAB);
        push_exp(6'd3, 32'd3, 32'hAB, 5'd7);
        tick(); clr_inputs();
        expect_idle("fwd.lat");
        tick();
        expect_issue("fwd");

        // rs_cdb wins over ls_cdb on identical tags at write time
        drive_write(6'd4, 32'h1, 5'd8, 32'h2, 5'd8, 5'd9);
        cdb_rs(5'd8, 32'h11);
        cdb_ls(5'd8, 32'h22);
        push_exp(6'd4, 32'h11, 32'h11, 5'd9);
        tick(); clr_inputs();
        tick();
        expect_issue("prio");

        // both operands woken in one cycle by the two CDBs
        drive_write(6'd5, 32'h0, 5'd2, 32'h0, 5'd3, 5'd10);
        push_exp(6'd5, 32'h20, 32'h30, 5'd10);
        tick(); clr_inputs();
        cdb_rs(5'd2, 32'h20);
        cdb_ls(5'd3, 32'h30);
        tick(); clr_inputs();
        expect_idle("dual.lat");
        tick();
        expect_issue("dual");
        tick();

        // fill: 16 accepted writes, 17th dropped; full asserts at 15 busy
        for (int i = 0; i < 17; i++) begin
            drive_write(6'd6, 32'h0, 5'd9, 32'(i), 5'd0, 5'(i + 1));
            if (i < 16) push_exp(6'd6, 32'h99, 32'(i), 5'(i + 1));
            tick(); clr_inputs();
            chk($sformatf("fill.full%0d", i + 1), 32'(full_to_if), 32'(i >= 14));
        end
        expect_idle("fill.wait");
        cdb_rs(5'd9, 32'h99);
        tick(); clr_inputs();
        expect_idle("fill.wake");
        for (int k = 1; k <= 16; k++) begin
            tick();
            expect_issue($sformatf("drain%0d", k));
            chk($sformatf("drain.full%0d", k), 32'(full_to_if), 32'(k < 2));
        end
        tick();
        expect_idle("drain.empty");

        // rollback overrides a pending issue and a concurrent write
        drive_write(6'd7, 32'h0, 5'd12, 32'h0, 5'd0, 5'd20);
        tick(); clr_inputs();
        drive_write(6'd7, 32'h0, 5'd12, 32'h0, 5'd0, 5'd21);
        tick(); clr_inputs();
        drive_write(6'd7, 32'h4, 5'd0, 32'h5, 5'd0, 5'd23);
        tick(); clr_inputs();
        expect_idle("rb.pre");
        rollback_from_rob = 1'b1;
        drive_write(6'd7, 32'h6, 5'd0, 32'h7, 5'd0, 5'd22);
        tick(); clr_inputs();
        expect_idle("rb.edge");
        chk("rb.full", 32'(full_to_if), 32'd0);
        cdb_rs(5'd12, 32'h12);
        tick(); clr_inputs();
        expect_idle("rb.after1");
        tick();
        expect_idle("rb.after2");

        // rdy low freezes entries and outputs, ignoring CDB and rollback
        drive_write(6'd8, 32'h0, 5'd13, 32'h8, 5'd0, 5'd25);
        push_exp(6'd8, 32'h55, 32'h8, 5'd25);
        tick(); clr_inputs();
        drive_write(6'd8, 32'h1, 5'd0, 32'h2, 5'd0, 5'd24);
        push_exp(6'd8, 32'h1, 32'h2, 5'd24);
        tick(); clr_inputs();
        expect_idle("frz.w1");
        drive_write(6'd8, 32'h3, 5'd0, 32'h4, 5'd0, 5'd26);
        push_exp(6'd8, 32'h3, 32'h4, 5'd26);
        exp_q.push_back(exp_q.pop_front());
        tick(); clr_inputs();
        expect_issue("frz.pre");
        rdy = 1'b0;
        cdb_rs(5'd13, 32'h66);
        drive_write(6'd8, 32'h9, 5'd0, 32'h9, 5'd0, 5'd27);
        for (int c = 0; c < 3; c++) begin
            rollback_from_rob = (c == 1);
            tick();
            chk($sformatf("frz.ena%0d", c), 32'(ena_to_alu), 32'd1);
            chk($sformatf("frz.rob%0d", c), 32'(rob_id_to_alu), 32'd24);
        end
        clr_inputs();
        rdy = 1'b1;
        tick();
        expect_issue("frz.resume");
        tick();
        expect_idle("frz.still_wait");
        cdb_rs(5'd13, 32'h55);
        tick(); clr_inputs();
        tick();
        expect_issue("frz.late");

        // reset mid-operation discards entries
        drive_write(6'd9, 32'h0, 5'd14, 32'h0, 5'd0, 5'd28);
        tick(); clr_inputs();
        rst = 1'b1;
        drive_write(6'd9, 32'h1, 5'd0, 32'h1, 5'd0, 5'd29);
        tick(); clr_inputs();
        rst = 1'b0;
        chk("mrst.ena", 32'(ena_to_alu), 32'd0);
        chk("mrst.rob", 32'(rob_id_to_alu), 32'd0);
        chk("mrst.full", 32'(full_to_if), 32'd0);
        cdb_rs(5'd14, 32'h14);
        tick(); clr_inputs();
        tick();
        expect_idle("mrst.after");

        chk("sb.empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
